branch_predictor_bht: RTL and testbench

//  Parametrised successor to the single-FSM branch predictor: a table of ENTRIES saturating
//  CTR_BITS counters, optionally gshare-indexed (GHR_BITS>0). Decode stage looks up; MEM stage

---
 rtl/bp_pkg.sv | 27 ++
 rtl/branch_predictor_bht_if.sv | 28 ++
 rtl/bp_counter_ram.sv | 25 ++
 rtl/branch_predictor_bht.sv | 115 +++++++++++
 tb/tb_branch_predictor_bht.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the BHT branch predictor: FSM encoding, counter constants
// derived from the counter width, and the parameter legality check.
package bp_pkg;

    typedef enum logic {
        BP_INIT  = 1'b0,
        BP_READY = 1'b1
    } bp_state_e;

    // Weakly-not-taken: the largest value whose MSB is still clear.
    function automatic int weak_nt(input int ctr_bits);
        return (1 << (ctr_bits - 1)) - 1;
    endfunction

    function automatic int max_ctr(input int ctr_bits);
        return (1 << ctr_bits) - 1;
    endfunction

    function automatic bit params_legal(input int entries, input int ctr_bits, input int ghr_bits);
        int idx_w;
        idx_w = $clog2(entries);
        return (entries >= 4) && ((entries & (entries - 1)) == 0) &&
               (ctr_bits >= 1) && (ctr_bits <= 4) &&
               (ghr_bits >= 0) && (ghr_bits <= idx_w);
    endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Decode-side lookup and MEM-side update bundle for the BHT predictor.
// master = CPU pipeline, slave = predictor.
interface branch_predictor_bht_if #(
    parameter int IDX_W = 6
);
    logic              lookup_valid;
    logic [31:0]       lookup_pc;
    logic [31:0]       lookup_offset;
    logic              prediction;
    logic [31:0]       branch_addr;
    logic [IDX_W-1:0]  lookup_index;
    logic              update_valid;
    logic [IDX_W-1:0]  update_index;
    logic              update_taken;
    logic              ready;

    modport master (
        output lookup_valid, lookup_pc, lookup_offset,
        output update_valid, update_index, update_taken,
        input  prediction, branch_addr, lookup_index, ready
    );

    modport slave (
        input  lookup_valid, lookup_pc, lookup_offset,
        input  update_valid, update_index, update_taken,
        output prediction, branch_addr, lookup_index, ready
    );
endinterface

// File: rtl/bp_counter_ram.sv
// ENTRIES x CTR_BITS counter storage: asynchronous reads, one synchronous write.
// Lookup and update both read the table in the same cycle, hence two read taps.
module bp_counter_ram #(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic [IDX_W-1:0]    rd_addr,
    output logic [CTR_BITS-1:0] rd_data,
    input  logic [IDX_W-1:0]    upd_addr,
    output logic [CTR_BITS-1:0] upd_data,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_addr,
    input  logic [CTR_BITS-1:0] wr_data
);
    logic [CTR_BITS-1:0] mem [ENTRIES];

    assign rd_data  = mem[rd_addr];
    assign upd_data = mem[upd_addr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end
endmodule

// File: rtl/branch_predictor_bht.sv
// Saturating-counter branch history table, bimodal or gshare indexed.
// Owns the init sweep FSM, global history and the counter update path.
module branch_predictor_bht
    import bp_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int CTR_BITS = 2,
    parameter int GHR_BITS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_predictor_bht_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_BITS-1:0] WEAK = CTR_BITS'(weak_nt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] MAXC = CTR_BITS'(max_ctr(CTR_BITS));

    if (!params_legal(ENTRIES, CTR_BITS, GHR_BITS)) begin : g_bad_params
        $error("branch_predictor_bht: illegal ENTRIES/CTR_BITS/GHR_BITS");
    end

    bp_state_e           state, state_nxt;
    logic [IDX_W-1:0]    ptr;
    logic                sweep_en;
    logic                ready_int;
    logic [IDX_W-1:0]    ghr_idx;
    logic [IDX_W-1:0]    lookup_idx;
    logic [CTR_BITS-1:0] rd_ctr, upd_ctr, sat_ctr;
    logic                upd_en;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_addr;
    logic [CTR_BITS-1:0] wr_data;
    logic                unused_pc_bits;

    always_ff @(posedge clk) begin
        if (rst) state <= BP_INIT;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BP_INIT:  if (ptr == IDX_W'(ENTRIES - 1)) state_nxt = BP_READY;
            BP_READY: state_nxt = BP_READY;
            default:  state_nxt = BP_INIT;
        endcase
    end

    // rst gates the outputs combinationally so nothing leaks during the reset cycle.
    always_comb begin
        sweep_en  = 1'b0;
        ready_int = 1'b0;
        case (state)
            BP_INIT:  sweep_en  = !rst;
            BP_READY: ready_int = !rst;
            default:  ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)           ptr <= '0;
        else if (sweep_en) ptr <= ptr + 1'b1;
    end

    if (GHR_BITS > 0) begin : g_ghr
        logic [GHR_BITS-1:0] ghr;

        // Newest outcome enters at the LSB.
        always_ff @(posedge clk) begin
            if (rst)                               ghr <= '0;
            else if (ready_int && bp.update_valid) ghr <= GHR_BITS'({ghr, bp.update_taken});
        end

        assign ghr_idx = rst ? '0 : IDX_W'(ghr);
    end else begin : g_no_ghr
        assign ghr_idx = '0;
    end

    assign lookup_idx      = bp.lookup_pc[IDX_W+1:2] ^ ghr_idx;
    assign unused_pc_bits  = ^{bp.lookup_pc[31:IDX_W+2], bp.lookup_pc[1:0]};

    bp_counter_ram #(
        .ENTRIES  (ENTRIES),
        .CTR_BITS (CTR_BITS),
        .IDX_W    (IDX_W)
    ) u_ram (
        .clk      (clk),
        .rd_addr  (lookup_idx),
        .rd_data  (rd_ctr),
        .upd_addr (bp.update_index),
        .upd_data (upd_ctr),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always_comb begin
        sat_ctr = upd_ctr;
        if (bp.update_taken) begin
            if (upd_ctr != MAXC) sat_ctr = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0)   sat_ctr = upd_ctr - 1'b1;
        end
    end

    assign upd_en  = ready_int & bp.update_valid;
    assign wr_en   = sweep_en | upd_en;
    assign wr_addr = sweep_en ? ptr  : bp.update_index;
    assign wr_data = sweep_en ? WEAK : sat_ctr;

    assign bp.lookup_index = lookup_idx;
    assign bp.prediction   = ready_int & bp.lookup_valid & rd_ctr[CTR_BITS-1];
    assign bp.branch_addr  = bp.lookup_pc + bp.lookup_offset;
    assign bp.ready        = ready_int;
endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for the BHT predictor: a bimodal and a gshare instance share clock/reset;
// a behavioural model feeds a scoreboard that is checked every cycle.
module tb_branch_predictor_bht;
    localparam int ENTRIES = 64;
    localparam int IDX_W   = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_bht_if #(.IDX_W(IDX_W)) bif ();
    branch_predictor_bht_if #(.IDX_W(IDX_W)) gif ();

    branch_predictor_bht #(.ENTRIES(ENTRIES), .CTR_BITS(2), .GHR_BITS(0)) u_bim (
        .clk (clk), .rst (rst), .bp (bif)
    );
    branch_predictor_bht #(.ENTRIES(ENTRIES), .CTR_BITS(2), .GHR_BITS(4)) u_gsh (
        .clk (clk), .rst (rst), .bp (gif)
    );

    typedef struct packed {
        logic             pred;
        logic [IDX_W-1:0] idx;
        logic [31:0]      addr;
        logic             rdy;
    } exp_t;

    exp_t       sb[$];
    int         mctr[2][ENTRIES];
    logic [3:0] mghr;
    int         minit;
    bit         mready;
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic exp_t model_out(input int lane, input logic lv,
                                       input logic [31:0] pc, input logic [31:0] off);
        exp_t e;
        logic [IDX_W-1:0] idx;
        idx    = pc[7:2] ^ ((lane == 1 && !rst) ? {2'b00, mghr} : 6'd0);
        e.idx  = idx;
        e.rdy  = mready && !rst;
        e.pred = e.rdy && lv && (mctr[lane][idx] >= 2);
        e.addr = pc + off;
        return e;
    endfunction

    function automatic int sat(input int c, input logic t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    // One clock: push expectations for the inputs now applied, check at negedge,
    // advance the model at posedge, return just after the edge.
    task automatic tick();
        exp_t e;
        sb.push_back(model_out(0, bif.lookup_valid, bif.lookup_pc, bif.lookup_offset));
        sb.push_back(model_out(1, gif.lookup_valid, gif.lookup_pc, gif.lookup_offset));
        @(negedge clk);
        e = sb.pop_front();
        chk("bim_pred",  bif.prediction,   e.pred);
        chk("bim_idx",   bif.lookup_index, e.idx);
        chk("bim_addr",  bif.branch_addr,  e.addr);
        chk("bim_ready", bif.ready,        e.rdy);
        e = sb.pop_front();
        chk("gsh_pred",  gif.prediction,   e.pred);
        chk("gsh_idx",   gif.lookup_index, e.idx);
        chk("gsh_ready", gif.ready,        e.rdy);
        @(posedge clk);
        if (rst) begin
            mready = 1'b0;
            minit  = 0;
            mghr   = '0;
        end else if (!mready) begin
            minit++;
            if (minit == ENTRIES) begin
                mready = 1'b1;
                foreach (mctr[l, i]) mctr[l][i] = 1;
            end
        end else begin
            if (bif.update_valid)
                mctr[0][bif.update_index] = sat(mctr[0][bif.update_index], bif.update_taken);
            if (gif.update_valid) begin
                mctr[1][gif.update_index] = sat(mctr[1][gif.update_index], gif.update_taken);
                mghr = {mghr[2:0], gif.update_taken};
            end
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic tseq [4];
        tseq = '{1'b1, 1'b1, 1'b0, 1'b1};
        mready = 1'b0; minit = 0; mghr = '0;
        bif.lookup_valid = 0; bif.lookup_pc = 0; bif.lookup_offset = 0;
        bif.update_valid = 0; bif.update_index = 0; bif.update_taken = 0;
        gif.lookup_valid = 0; gif.lookup_pc = 0; gif.lookup_offset = 0;
        gif.update_valid = 0; gif.update_index = 0; gif.update_taken = 0;

        // Reset and init sweep: ready low for 64 cycles, predictions suppressed.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            bif.lookup_valid = 1; bif.lookup_pc = 32'(i * 4);
            gif.lookup_valid = 1; gif.lookup_pc = 32'(i * 4);
            tick();
        end
        chk("ready_after_64", bif.ready, 1'b1);

        // Every counter at WEAK_NT: a taken update (colliding with the lookup) flips it.
        for (int i = 0; i < ENTRIES; i++) begin
            bif.lookup_pc = 32'(i * 4);
            bif.update_valid = 1; bif.update_index = 6'(i); bif.update_taken = 1;
            tick();
            bif.update_valid = 0;
            tick();
            bif.update_valid = 1; bif.update_taken = 0;
            tick();
            bif.update_valid = 0;
        end

        // Saturation at pc 0x100 (index 0).
        bif.lookup_pc = 32'h100; bif.update_index = 6'd0; bif.update_valid = 1;
        bif.update_taken = 1;
        repeat (3) tick();
        bif.update_taken = 0;
        repeat (4) tick();
        bif.update_valid = 0;
        tick();

        // Gshare history T,T,N,T then lookup at 0x40.
        gif.update_valid = 1; gif.update_index = 6'd5;
        for (int i = 0; i < 4; i++) begin
            gif.update_taken = tseq[i];
            tick();
        end
        gif.update_valid = 0; gif.lookup_pc = 32'h40;
        #2 chk("gshare_idx", gif.lookup_index, 6'h1D);
        tick();

        // Target wrap-around.
        bif.lookup_pc = 32'hFFFF_FFF0; bif.lookup_offset = 32'h20;
        #2 chk("target_wrap", bif.branch_addr, 32'h0000_0010);
        tick();
        bif.lookup_offset = -32'sd8;
        #2 chk("target_neg", bif.branch_addr, 32'hFFFF_FFE8);
        tick();
        bif.lookup_offset = 0;

        // Reset mid-sweep with updates held active during INIT.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bif.update_valid = 1; bif.update_index = 6'd3; bif.update_taken = 1;
        gif.update_valid = 1; gif.update_taken = 1;
        bif.lookup_pc = 32'hC;
        repeat (30) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (63) tick();
        chk("ready_low_63", bif.ready, 1'b0);
        tick();
        chk("ready_high_64", gif.ready, 1'b1);
        bif.update_valid = 0; gif.update_valid = 0;
        gif.lookup_pc = 32'h40;
        #2 chk("ghr_held_idx", gif.lookup_index, 6'h10);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
